// File: rtl/bit_reverse_reorder.sv
// Ping-pong reorder buffer: accepts 2^LOG2N-point FFT frames in bit-reversed order and emits them in natural order.
// Optional feature: define BITREV_FRAME_CNT_EN to add the 8-bit frame_cnt_o output.
module bit_reverse_reorder #(
    parameter int DATA_W = 16,
    parameter int LOG2N  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    input  logic signed [DATA_W-1:0] data_in_r,
    input  logic signed [DATA_W-1:0] data_in_i,
    output logic                     valid_o,
    output logic                     frame_start_o,
    output logic signed [DATA_W-1:0] data_out_r,
    output logic signed [DATA_W-1:0] data_out_i
`ifdef BITREV_FRAME_CNT_EN
    ,
    output logic [7:0]               frame_cnt_o
`endif
);

    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    typedef enum logic {IDLE, READ} state_t;

    state_t             state_q, state_d;
    logic [LOG2N-1:0]   wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic               wbank_q, wbank_d, rbank_q, rbank_d;
    logic [1:0]         full_q, full_d, full_set, full_clr;
    logic               rd_en;
    logic [2*DATA_W-1:0] mem [2][N];
    logic [2*DATA_W-1:0] rd_word;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int b = 0; b < LOG2N; b++) r[b] = v[LOG2N-1-b];
        return r;
    endfunction

    // Write side: counters advance only on accepted samples.
    always_comb begin
        wcnt_d   = wcnt_q;
        wbank_d  = wbank_q;
        full_set = '0;
        if (valid_i) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == LAST) begin
                full_set[wbank_q] = 1'b1;
                wbank_d           = ~wbank_q;
            end
        end
    end

    // Read FSM: the IDLE cycle that sees a full bank already emits index 0,
    // so the first output lands one edge after the frame's last sample.
    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        rbank_d  = rbank_q;
        rd_en    = 1'b0;
        full_clr = '0;
        case (state_q)
            IDLE: begin
                if (full_q[rbank_q]) begin
                    rd_en   = 1'b1;
                    rcnt_d  = rcnt_q + 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                rd_en  = 1'b1;
                rcnt_d = rcnt_q + 1'b1;
                if (rcnt_q == LAST) begin
                    full_clr[rbank_q] = 1'b1;
                    rbank_d           = ~rbank_q;
                    if (!(full_q[!rbank_q] || full_set[!rbank_q])) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign full_d  = (full_q | full_set) & ~full_clr;
    assign rd_word = mem[rbank_q][rcnt_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            full_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            full_q  <= full_d;
        end
    end

    // Bank storage carries no reset.
    always_ff @(posedge clk) begin
        if (!rst && valid_i) mem[wbank_q][bitrev(wcnt_q)] <= {data_in_r, data_in_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o       <= 1'b0;
            frame_start_o <= 1'b0;
            data_out_r    <= '0;
            data_out_i    <= '0;
        end else begin
            valid_o       <= rd_en;
            frame_start_o <= rd_en && (rcnt_q == '0);
            if (rd_en) {data_out_r, data_out_i} <= rd_word;
        end
    end

`ifdef BITREV_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) frame_cnt_o <= '0;
        else if (rd_en && rcnt_q == LAST) frame_cnt_o <= frame_cnt_o + 8'd1;
    end
`endif

endmodule

// File: tb/tb_bit_reverse_reorder.sv
// Directed bench for bit_reverse_reorder: timing, ordering, gaps, back-to-back frames and resets.
module tb_bit_reverse_reorder;

    logic               clk, rst, valid_i;
    logic signed [15:0] data_in_r, data_in_i;
    logic               valid_o, frame_start_o;
    logic signed [15:0] data_out_r, data_out_i;
`ifdef BITREV_FRAME_CNT_EN
    logic [7:0]         frame_cnt_o;
`endif

    int asserts = 0;
    int fails   = 0;
    int cyc     = 0;

    typedef struct {
        int                 cyc;
        logic signed [15:0] r;
        logic signed [15:0] i;
        logic               fs;
    } cap_t;
    cap_t capq[$];

    bit_reverse_reorder #(.DATA_W(16), .LOG2N(5)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i),
        .data_in_r(data_in_r), .data_in_i(data_in_i),
        .valid_o(valid_o), .frame_start_o(frame_start_o),
        .data_out_r(data_out_r), .data_out_i(data_out_i)
`ifdef BITREV_FRAME_CNT_EN
        , .frame_cnt_o(frame_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every valid output, tagged with the edge number that registered it.
    always @(negedge clk) if (valid_o) capq.push_back('{cyc, data_out_r, data_out_i, frame_start_o});

    function automatic int brev5(input int v);
        int r = 0;
        for (int b = 0; b < 5; b++) if (v[b]) r |= 1 << (4 - b);
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; valid_i = 1'b0;
        @(negedge clk); rst = 1'b0;
        capq.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); valid_i = 1'b0; end
    endtask

    // Drives one frame (sample k = base+k); e returns the edge capturing sample 31.
    task automatic send_frame(input int base, input bit gap, output int e);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            valid_i = 1'b1; data_in_r = 16'(base + k); data_in_i = 16'(-(base + k));
            if (k == 31) e = cyc + 1;
            if (gap && k < 31) begin
                @(negedge clk);
                valid_i = 1'b0; data_in_r = 16'sh7fff; data_in_i = 16'sh7fff;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        asserts++;
        if (valid_o !== 1'b0 || frame_start_o !== 1'b0 || data_out_r !== 16'sd0 || data_out_i !== 16'sd0) begin
            fails++;
            $display("FAIL reset_state: got v=%b fs=%b r=%0d i=%0d, want all 0", valid_o, frame_start_o, data_out_r, data_out_i);
        end
`ifdef BITREV_FRAME_CNT_EN
        asserts++;
        if (frame_cnt_o !== 8'd0) begin
            fails++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt_o);
        end
`endif
    endtask

    task automatic test_single_frame();
        int e, x;
        do_reset();
        send_frame(0, 1'b0, e);
        idle(40);
        asserts++;
        if (capq.size() != 32) begin
            fails++; $display("FAIL single_len: got %0d outputs want 32", capq.size());
        end
        for (int n = 0; n < 32 && n < capq.size(); n++) begin
            x = brev5(n);
            asserts++;
            if (capq[n].cyc != e + 1 + n || capq[n].r !== 16'(x) || capq[n].i !== 16'(-x) || capq[n].fs !== (n == 0)) begin
                fails++;
                $display("FAIL single[%0d]: got edge=%0d r=%0d i=%0d fs=%b want edge=%0d r=%0d i=%0d fs=%b",
                         n, capq[n].cyc, capq[n].r, capq[n].i, capq[n].fs, e + 1 + n, x, -x, n == 0);
            end
        end
`ifdef BITREV_FRAME_CNT_EN
        asserts++;
        if (frame_cnt_o !== 8'd1) begin
            fails++; $display("FAIL single_frame_cnt: got %0d want 1", frame_cnt_o);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int e0, e, x;
        do_reset();
        send_frame(0, 1'b0, e0);
        send_frame(100, 1'b0, e);
        send_frame(200, 1'b0, e);
        idle(40);
        asserts++;
        if (capq.size() != 96) begin
            fails++; $display("FAIL b2b_len: got %0d outputs want 96", capq.size());
        end
        for (int j = 0; j < 96 && j < capq.size(); j++) begin
            x = 100 * (j / 32) + brev5(j % 32);
            asserts++;
            if (capq[j].cyc != e0 + 1 + j || capq[j].r !== 16'(x) || capq[j].i !== 16'(-x) || capq[j].fs !== (j % 32 == 0)) begin
                fails++;
                $display("FAIL b2b[%0d]: got edge=%0d r=%0d i=%0d fs=%b want edge=%0d r=%0d i=%0d fs=%b",
                         j, capq[j].cyc, capq[j].r, capq[j].i, capq[j].fs, e0 + 1 + j, x, -x, j % 32 == 0);
            end
        end
    endtask

    task automatic test_gapped_input();
        int e, x;
        do_reset();
        send_frame(50, 1'b1, e);
        idle(40);
        asserts++;
        if (capq.size() != 32) begin
            fails++; $display("FAIL gap_len: got %0d outputs want 32", capq.size());
        end
        for (int n = 0; n < 32 && n < capq.size(); n++) begin
            x = 50 + brev5(n);
            asserts++;
            if (capq[n].cyc != e + 1 + n || capq[n].r !== 16'(x) || capq[n].i !== 16'(-x) || capq[n].fs !== (n == 0)) begin
                fails++;
                $display("FAIL gap[%0d]: got edge=%0d r=%0d i=%0d fs=%b want edge=%0d r=%0d i=%0d",
                         n, capq[n].cyc, capq[n].r, capq[n].i, capq[n].fs, e + 1 + n, x, -x);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int e, x;
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk); valid_i = 1'b1; data_in_r = 16'(300 + k); data_in_i = 16'(-(300 + k));
        end
        // valid_i stays high through reset and must be ignored.
        @(negedge clk); rst = 1'b1; data_in_r = 16'sd999; data_in_i = 16'sd999;
        @(negedge clk); rst = 1'b0; valid_i = 1'b0;
        capq.delete();
        send_frame(400, 1'b0, e);
        idle(40);
        asserts++;
        if (capq.size() != 32) begin
            fails++; $display("FAIL rstframe_len: got %0d outputs want 32", capq.size());
        end
        for (int n = 0; n < 32 && n < capq.size(); n++) begin
            x = 400 + brev5(n);
            asserts++;
            if (capq[n].cyc != e + 1 + n || capq[n].r !== 16'(x) || capq[n].i !== 16'(-x)) begin
                fails++;
                $display("FAIL rstframe[%0d]: got edge=%0d r=%0d i=%0d want edge=%0d r=%0d i=%0d",
                         n, capq[n].cyc, capq[n].r, capq[n].i, e + 1 + n, x, -x);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int e;
        do_reset();
        send_frame(500, 1'b0, e);
        @(negedge clk); valid_i = 1'b0;
        while (cyc < e + 6) @(negedge clk);
        asserts++;
        if (valid_o !== 1'b1 || data_out_r !== 16'sd520) begin
            fails++; $display("FAIL burst_idx5: got v=%b r=%0d want v=1 r=520", valid_o, data_out_r);
        end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        asserts++;
        if (valid_o !== 1'b0 || frame_start_o !== 1'b0 || data_out_r !== 16'sd0 || data_out_i !== 16'sd0) begin
            fails++;
            $display("FAIL burst_rst: got v=%b fs=%b r=%0d i=%0d want all 0", valid_o, frame_start_o, data_out_r, data_out_i);
        end
        idle(40);
        asserts++;
        if (capq.size() != 6) begin
            fails++; $display("FAIL burst_resume: got %0d outputs want 6", capq.size());
        end
    endtask

`ifdef BITREV_FRAME_CNT_EN
    task automatic test_frame_cnt();
        int e;
        do_reset();
        for (int f = 0; f < 257; f++) send_frame(f % 64, 1'b0, e);
        idle(40);
        asserts++;
        if (frame_cnt_o !== 8'd1) begin
            fails++; $display("FAIL frame_cnt_wrap: got %0d want 1", frame_cnt_o);
        end
        capq.delete();
    endtask
`endif

    initial begin
        rst = 1'b0; valid_i = 1'b0; data_in_r = '0; data_in_i = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gapped_input();
        test_reset_mid_frame();
        test_reset_mid_burst();
`ifdef BITREV_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
